// File: rtl/fir_folded_sym.sv
// fir_folded_sym: symmetric FIR with one pre-adder, multiplier and accumulator, time-shared over
// HALF folded taps per sample. Build option FIR_SAT_EN: saturating y_out plus a sat_flag output.
module fir_folded_sym #(
  parameter int N_TAPS = 63,
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int OW     = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            coef_we,
  input  logic [$clog2((N_TAPS+1)/2)-1:0] coef_addr,
  input  logic signed [CW-1:0]            coef_din,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DW-1:0]            x_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OW-1:0]            y_out,
  output logic                            busy
`ifdef FIR_SAT_EN
  ,
  output logic                            sat_flag
`endif
);

  localparam int HALF = (N_TAPS + 1) / 2;
  localparam int KW   = $clog2(HALF);
  localparam int IW   = $clog2(N_TAPS);
  localparam int PW   = DW + CW + 1;
  localparam int AW   = PW + KW;
  localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);
  localparam logic [KW:0]   HALF_C = (KW+1)'(HALF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [OW-1:0]         y_q, y_d;
  logic                  ov_q, ov_d;
  logic                  sat_q, sat_d;

  logic signed [DW-1:0]  dly_q  [N_TAPS];
  logic signed [CW-1:0]  coef_q [HALF];

  logic                  accept;
  logic                  coef_wr;
  logic [IW-1:0]         lo_idx, hi_idx;
  logic signed [DW:0]    tap_lo, tap_hi, pre;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc_sum;
  logic [OW-1:0]         y_res;
  logic                  y_clip;

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign coef_wr  = (state_q == S_IDLE) && coef_we && ({1'b0, coef_addr} < HALF_C);
  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign y_out    = y_q;
`ifdef FIR_SAT_EN
  assign sat_flag = sat_q;
`endif

  // Coefficient store: a write in the accept cycle lands before the first MAC reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HALF; i++) coef_q[i] <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) dly_q[i] <= '0;
    end else if (accept) begin
      dly_q[0] <= x_in;
      for (int i = 1; i < N_TAPS; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // Folded datapath: tap k pairs with its mirror; the centre tap stands alone.
  always_comb begin
    lo_idx  = IW'(k_q);
    hi_idx  = IW'(N_TAPS - 1) - lo_idx;
    tap_lo  = {dly_q[lo_idx][DW-1], dly_q[lo_idx]};
    tap_hi  = (k_q == K_LAST) ? '0 : {dly_q[hi_idx][DW-1], dly_q[hi_idx]};
    pre     = tap_lo + tap_hi;
    prod    = pre * coef_q[k_q];
    acc_sum = acc_q + {{KW{prod[PW-1]}}, prod};
  end

`ifdef FIR_SAT_EN
  logic [AW-OW:0] top_bits;
  always_comb begin
    top_bits = acc_sum[AW-1:OW-1];
    y_clip   = !((&top_bits) || !(|top_bits));
    if (!y_clip)             y_res = acc_sum[OW-1:0];
    else if (acc_sum[AW-1])  y_res = {1'b1, {(OW-1){1'b0}}};
    else                     y_res = {1'b0, {(OW-1){1'b1}}};
  end
`else
  always_comb begin
    y_res  = acc_sum[OW-1:0];
    y_clip = 1'b0;
  end
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    y_d     = y_q;
    ov_d    = ov_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_MAC;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_OUT;
          k_d     = '0;
          y_d     = y_res;
          sat_d   = y_clip;
          ov_d    = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          ov_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_fir_folded_sym.sv
// Bench for fir_folded_sym: scoreboard fed by a direct-form model, impulse vector table,
// and hand sequences for backpressure, busy coefficient writes, overflow and mid-MAC reset.
`timescale 1ns/1ps
module tb_fir_folded_sym;
  localparam int N_TAPS = 63;
  localparam int HALF   = 32;
  localparam int DW     = 16;
  localparam int CW     = 16;
  localparam int OW     = 32;
  localparam int KW     = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coef_we;
  logic [KW-1:0] coef_addr;
  logic [CW-1:0] coef_din;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] y_out;
  logic          busy;
`ifdef FIR_SAT_EN
  logic          sat_flag;
`endif

  fir_folded_sym dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_din  (coef_din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .busy      (busy)
`ifdef FIR_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [OW-1:0] y; logic sat; } exp_t;
  typedef struct { logic [DW-1:0] x; logic [OW-1:0] y; } vec_t;

  exp_t          sb_q[$];
  vec_t          vecs[N_TAPS];
  int            md[N_TAPS];
  int            mc[HALF];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            acc_last = 0;
  int            acc_prev = 0;
  int            last_lat = -1;
  int            out_cnt = 0;
  logic          ov_prev = 1'b0;
  logic [OW-1:0] last_y = '0;
  logic          last_sat = 1'b0;
  bit            use_tbl = 1'b0;
  logic [OW-1:0] tbl_y = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic fail_event(input string name, input int info);
    n_checks++;
    $display("FAIL %s: got %0d, required completion", name, info);
  endtask

  function automatic exp_t model_out();
    exp_t   e;
    longint acc = 0;
    for (int t = 0; t < N_TAPS; t++) begin
      int ci = (t < HALF) ? t : (N_TAPS - 1 - t);
      acc += longint'(mc[ci]) * longint'(md[t]);
    end
`ifdef FIR_SAT_EN
    if (acc > 64'sd2147483647) begin
      e.y = 32'h7FFF_FFFF; e.sat = 1'b1;
    end else if (acc < -64'sd2147483648) begin
      e.y = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.y = acc[31:0]; e.sat = 1'b0;
    end
`else
    e.y = acc[31:0];
    e.sat = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < N_TAPS; t++) md[t] = 0;
    for (int k = 0; k < HALF; k++) mc[k] = 0;
    sb_q.delete();
  endtask

  // Called at a negedge with the inputs for the next posedge already driven.
  task automatic step();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        fail_event("unexpected_output", int'(y_out));
      end else begin
        e = sb_q.pop_front();
        $display("out %0d: y_out=%h expected=%h", out_cnt, y_out, e.y);
        check("y_out", y_out, e.y);
`ifdef FIR_SAT_EN
        check("sat_flag", sat_flag, e.sat);
        last_sat = sat_flag;
`endif
        last_y = y_out;
        out_cnt++;
      end
    end
    if (coef_we && in_ready) mc[coef_addr] = int'($signed(coef_din));
    if (in_valid && in_ready) begin
      for (int t = N_TAPS - 1; t > 0; t--) md[t] = md[t-1];
      md[0] = int'($signed(x_in));
      e = model_out();
      if (use_tbl) e.y = tbl_y;
      sb_q.push_back(e);
      acc_prev = acc_last;
      acc_last = cyc;
    end
    if (out_valid && !ov_prev) last_lat = cyc - acc_last;
    ov_prev = out_valid;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [DW-1:0] x);
    in_valid = 1'b1;
    x_in = x;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0;
    fail_event("accept_timeout", cyc);
  endtask

  task automatic wcoef(input logic [KW-1:0] a, input logic [CW-1:0] v);
    for (int i = 0; i < 200 && !in_ready; i++) step();
    coef_we = 1'b1;
    coef_addr = a;
    coef_din = v;
    step();
    coef_we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb_q.size() > 0; i++) step();
    if (sb_q.size() > 0) fail_event("drain_timeout", sb_q.size());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ov_prev = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] held;
    bit            stable;
    int            cnt0;
    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_din = '0;
    in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y_out", y_out, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Coefficient write and accept in the same idle cycle.
    coef_we = 1'b1; coef_addr = 5'd0; coef_din = 16'd4;
    in_valid = 1'b1; x_in = 16'd3;
    step();
    coef_we = 1'b0; in_valid = 1'b0;
    drain();
    check("same_cycle_write_y", last_y, 32'd12);
    check("latency", last_lat, HALF + 1);

    // Impulse response with c[k] = k+1, checked against a fixed vector table.
    do_reset();
    for (int i = 0; i < N_TAPS; i++) begin
      vecs[i].x = (i == 0) ? 16'd1 : 16'd0;
      vecs[i].y = (i < HALF) ? OW'(i + 1) : OW'(N_TAPS - i);
    end
    for (int k = 0; k < HALF; k++) wcoef(KW'(k), CW'(k + 1));
    cnt0 = out_cnt;
    use_tbl = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      tbl_y = vecs[i].y;
      send(vecs[i].x);
    end
    use_tbl = 1'b0;
    drain();
    check("impulse_count", out_cnt - cnt0, N_TAPS);
    check("throughput", acc_last - acc_prev, HALF + 2);

    // Coefficient write attempted while busy must be dropped.
    send(16'd1);
    check("busy_in_mac", busy, 1);
    coef_we = 1'b1; coef_addr = 5'd0; coef_din = 16'h7FFF;
    repeat (5) step();
    coef_we = 1'b0;
    drain();
    check("busy_write_ignored_y", last_y, 32'd1);

    // Backpressure: output held, input not consumed.
    out_ready = 1'b0;
    send(16'd5);
    for (int i = 0; i < 100 && !out_valid; i++) step();
    held = y_out;
    in_valid = 1'b1; x_in = 16'd9;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      stable &= (out_valid === 1'b1) && (y_out === held) && (in_ready === 1'b0);
    end
    check("bp_stable", stable, 1);
    check("bp_held_y", held, 32'd7);
    out_ready = 1'b1;
    step();
    check("ov_drop_after_hs", out_valid, 0);
    send(16'd9);
    drain();
    check("bp_next_sample_y", last_y, 32'd22);

    // DC response with unit coefficients.
    for (int k = 0; k < HALF; k++) wcoef(KW'(k), 16'd1);
    for (int i = 0; i < 66; i++) send(16'd100);
    drain();
    check("dc_settled", last_y, 32'd6300);
    check("dc_throughput", acc_last - acc_prev, HALF + 2);

    // Full-scale overflow.
    for (int k = 0; k < HALF; k++) wcoef(KW'(k), 16'h7FFF);
    for (int i = 0; i < N_TAPS; i++) send(16'h7FFF);
    drain();
`ifdef FIR_SAT_EN
    check("overflow_y", last_y, 32'h7FFF_FFFF);
    check("overflow_sat", last_sat, 1);
`else
    check("overflow_y", last_y, 32'hBFC1_003F);
`endif

    // Reset in the middle of MAC.
    send(16'd3);
    repeat (10) step();
    check("mid_mac_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_y_out", y_out, 0);
    check("mid_rst_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ov_prev = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    send(16'd7);
    drain();
    check("post_rst_zero_coef_y", last_y, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
